// File: rtl/scc_f25_system_if.sv
// Core-to-memory bus of the SCC-F25: instruction fetch plus one data port.
interface scc_mem_if #(
  parameter int PCW = 8,
  parameter int DAW = 8
);
  logic [PCW-1:0] pc;
  logic [31:0]    instr;
  logic [DAW-1:0] daddr;
  logic           dwe;
  logic [31:0]    wdata;
  logic [31:0]    rdata;

  modport master (output pc, daddr, dwe, wdata, input instr, rdata);
  modport slave  (input pc, daddr, dwe, wdata, output instr, rdata);
endinterface

// File: rtl/scc_f25_system.sv
// SCC-F25 single-cycle 32-bit core with instruction ROM and data RAM.
// Optional feature macro: SCC_MUL_EN (opcode D becomes MUL; otherwise illegal).
module scc_f25_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [3:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] dbg_R0,  dbg_R1,  dbg_R2,  dbg_R3,
  output logic [31:0] dbg_R4,  dbg_R5,  dbg_R6,  dbg_R7,
  output logic [31:0] dbg_R8,  dbg_R9,  dbg_R10, dbg_R11,
  output logic [31:0] dbg_R12, dbg_R13, dbg_R14, dbg_R15
);
  logic [15:0][31:0] regs_q, regs_d;

  // R0 is never written, so its flop holds the reset zero forever
  always_comb begin
    regs_d = regs_q;
    if (we && wa != 4'd0) regs_d[wa] = wd;
  end

  always_ff @(posedge clk) begin
    if (rst) regs_q <= '0;
    else     regs_q <= regs_d;
  end

  assign dbg_R0  = regs_q[0];  assign dbg_R1  = regs_q[1];
  assign dbg_R2  = regs_q[2];  assign dbg_R3  = regs_q[3];
  assign dbg_R4  = regs_q[4];  assign dbg_R5  = regs_q[5];
  assign dbg_R6  = regs_q[6];  assign dbg_R7  = regs_q[7];
  assign dbg_R8  = regs_q[8];  assign dbg_R9  = regs_q[9];
  assign dbg_R10 = regs_q[10]; assign dbg_R11 = regs_q[11];
  assign dbg_R12 = regs_q[12]; assign dbg_R13 = regs_q[13];
  assign dbg_R14 = regs_q[14]; assign dbg_R15 = regs_q[15];
endmodule

module scc_f25_core #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  scc_mem_if.master   mem,
  output logic        halt_f,
  output logic [1:0]  err_bits,
  output logic [31:0] st_data
);
  localparam int PCW = $clog2(IMEM_DEPTH);
  localparam logic [3:0] OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
                         OP_OR  = 4'h4, OP_XOR = 4'h5, OP_ADDI = 4'h6, OP_LUI = 4'h7,
                         OP_LD  = 4'h8, OP_ST  = 4'h9, OP_BEQ = 4'hA, OP_BNE = 4'hB,
                         OP_JMP = 4'hC, OP_MUL = 4'hD, OP_HALT = 4'hF;

  logic [PCW-1:0] pc_q, pc_d;
  logic           halt_q, halt_d;
  logic [1:0]     err_q, err_d;
  logic           rf_we, dwe;
  logic [31:0]    rf_wd;
  logic [31:0]    r [16];

  logic [3:0]  op, rd, rs1, rs2;
  logic [15:0] imm;
  logic [31:0] simm, rd_v, rs1_v, rs2_v, ea;
  logic        addr_ok;

  assign {op, rd, rs1, rs2, imm} = mem.instr;
  assign simm    = {{16{imm[15]}}, imm};
  assign rd_v    = r[rd];
  assign rs1_v   = r[rs1];
  assign rs2_v   = r[rs2];
  assign ea      = rs1_v + simm;
  assign addr_ok = ea < 32'(DMEM_DEPTH);

  always_comb begin
    pc_d   = pc_q + 1'b1;
    halt_d = halt_q;
    err_d  = err_q;
    rf_we  = 1'b0;
    rf_wd  = '0;
    dwe    = 1'b0;
    case (op)
      OP_NOP: ;
      OP_ADD:  begin rf_we = 1'b1; rf_wd = rs1_v + rs2_v; end
      OP_SUB:  begin rf_we = 1'b1; rf_wd = rs1_v - rs2_v; end
      OP_AND:  begin rf_we = 1'b1; rf_wd = rs1_v & rs2_v; end
      OP_OR:   begin rf_we = 1'b1; rf_wd = rs1_v | rs2_v; end
      OP_XOR:  begin rf_we = 1'b1; rf_wd = rs1_v ^ rs2_v; end
      OP_ADDI: begin rf_we = 1'b1; rf_wd = ea; end
      OP_LUI:  begin rf_we = 1'b1; rf_wd = {imm, 16'h0}; end
      OP_LD, OP_ST: begin
        // faulting accesses freeze on the offending word with no side effects
        if (!addr_ok) begin
          err_d[1] = 1'b1; halt_d = 1'b1; pc_d = pc_q;
        end else if (op == OP_LD) begin
          rf_we = 1'b1; rf_wd = mem.rdata;
        end else begin
          dwe = 1'b1;
        end
      end
      OP_BEQ: if (rd_v == rs1_v) pc_d = pc_q + 1'b1 + simm[PCW-1:0];
      OP_BNE: if (rd_v != rs1_v) pc_d = pc_q + 1'b1 + simm[PCW-1:0];
      OP_JMP: pc_d = imm[PCW-1:0];
      OP_MUL: begin
`ifdef SCC_MUL_EN
        rf_we = 1'b1; rf_wd = rs1_v * rs2_v;
`else
        err_d[0] = 1'b1; halt_d = 1'b1; pc_d = pc_q;
`endif
      end
      OP_HALT: begin halt_d = 1'b1; pc_d = pc_q; end
      default: begin err_d[0] = 1'b1; halt_d = 1'b1; pc_d = pc_q; end
    endcase
    if (!clk_en || halt_q) begin
      pc_d = pc_q; halt_d = halt_q; err_d = err_q; rf_we = 1'b0; dwe = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0; halt_q <= 1'b0; err_q <= '0;
    end else begin
      pc_q <= pc_d; halt_q <= halt_d; err_q <= err_d;
    end
  end

  scc_f25_regfile REGFILE (
    .clk(clk), .rst(rst), .we(rf_we), .wa(rd), .wd(rf_wd),
    .dbg_R0(r[0]),   .dbg_R1(r[1]),   .dbg_R2(r[2]),   .dbg_R3(r[3]),
    .dbg_R4(r[4]),   .dbg_R5(r[5]),   .dbg_R6(r[6]),   .dbg_R7(r[7]),
    .dbg_R8(r[8]),   .dbg_R9(r[9]),   .dbg_R10(r[10]), .dbg_R11(r[11]),
    .dbg_R12(r[12]), .dbg_R13(r[13]), .dbg_R14(r[14]), .dbg_R15(r[15])
  );

  assign mem.pc    = pc_q;
  assign mem.daddr = ea[$bits(mem.daddr)-1:0];
  assign mem.dwe   = dwe;
  assign mem.wdata = rd_v;
  assign halt_f    = halt_q;
  assign err_bits  = err_q;
  assign st_data   = (op == OP_ST && !halt_q) ? rd_v : 32'h0;
endmodule

module scc_f25_system #(
  parameter int    IMEM_DEPTH = 256,
  parameter int    DMEM_DEPTH = 256,
  parameter string IMEM_FILE  = "imem.hex"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  output logic        halt_f,
  output logic [1:0]  err_bits,
  output logic [31:0] instruction_memory_v,
  output logic [31:0] data_memory_in_v
);
  localparam int PCW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  scc_mem_if #(.PCW(PCW), .DAW(DAW)) mem ();

  logic [31:0] imem   [IMEM_DEPTH];
  logic [31:0] dmem_q [DMEM_DEPTH];

  assign mem.instr = imem[mem.pc];
  assign mem.rdata = dmem_q[mem.daddr];

  always_ff @(posedge clk) begin
    if (mem.dwe) dmem_q[mem.daddr] <= mem.wdata;
  end

  scc_f25_core #(.IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH)) scc (
    .clk(clk), .rst(rst), .clk_en(clk_en), .mem(mem.master),
    .halt_f(halt_f), .err_bits(err_bits), .st_data(data_memory_in_v)
  );

  assign instruction_memory_v = mem.instr;
endmodule

// File: tb/tb_scc_f25_system.sv
// Bench for scc_f25_system: directed programs, an ALU vector table and random programs vs an ISA model.
module tb_scc_f25_system;
  logic        clk = 1'b0, rst = 1'b1, clk_en = 1'b0;
  logic        halt_f;
  logic [1:0]  err_bits;
  logic [31:0] imv, dmiv;
  int n_cmp = 0, n_err = 0;

  localparam int ADD = 1, SUB = 2, AND_ = 3, OR_ = 4, XOR_ = 5, ADDI = 6, LUI = 7,
                 LD = 8, ST = 9, BEQ = 10, BNE = 11, JMP = 12, MUL = 13, ILL = 14;
  localparam logic [31:0] HALTW = 32'hF000_0000;

  always #5 clk = ~clk;

  scc_f25_system #(.IMEM_FILE("")) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .halt_f(halt_f), .err_bits(err_bits),
    .instruction_memory_v(imv), .data_memory_in_v(dmiv)
  );

  logic [31:0] prog[$];

  function automatic logic [31:0] enc(int op, int rd, int rs1, int rs2, int imm);
    return {op[3:0], rd[3:0], rs1[3:0], rs2[3:0], imm[15:0]};
  endfunction

  task automatic emit(int op, int rd, int rs1, int rs2, int imm);
    prog.push_back(enc(op, rd, rs1, rs2, imm));
  endtask

  // load an arbitrary 32-bit constant with LUI + ADDI (ADDI sign-extends)
  task automatic li(int rd, logic [31:0] x);
    logic [31:0] lo, hi;
    lo = {{16{x[15]}}, x[15:0]};
    hi = x - lo;
    emit(LUI, rd, 0, 0, int'(hi[31:16]));
    emit(ADDI, rd, rd, 0, int'(x[15:0]));
  endtask

  task automatic load_prog();
    for (int i = 0; i < 256; i++) dut.imem[i] = (i < prog.size()) ? prog[i] : HALTW;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; repeat (3) tick(); rst = 1'b0;
  endtask

  task automatic run(int n, logic en);
    clk_en = en; repeat (n) tick();
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rf(int i);
    case (i)
      0: return dut.scc.REGFILE.dbg_R0;   1: return dut.scc.REGFILE.dbg_R1;
      2: return dut.scc.REGFILE.dbg_R2;   3: return dut.scc.REGFILE.dbg_R3;
      4: return dut.scc.REGFILE.dbg_R4;   5: return dut.scc.REGFILE.dbg_R5;
      6: return dut.scc.REGFILE.dbg_R6;   7: return dut.scc.REGFILE.dbg_R7;
      8: return dut.scc.REGFILE.dbg_R8;   9: return dut.scc.REGFILE.dbg_R9;
      10: return dut.scc.REGFILE.dbg_R10; 11: return dut.scc.REGFILE.dbg_R11;
      12: return dut.scc.REGFILE.dbg_R12; 13: return dut.scc.REGFILE.dbg_R13;
      14: return dut.scc.REGFILE.dbg_R14; default: return dut.scc.REGFILE.dbg_R15;
    endcase
  endfunction

  function automatic logic [31:0] pc();
    return 32'(dut.scc.pc_q);
  endfunction

  // ISA-level reference: interprets the program word by word until HALT or fault
  logic [31:0] m_reg [16];
  logic [31:0] m_dmem [256];
  logic [7:0]  m_pc;
  logic        m_halt;
  logic [1:0]  m_err;

  task automatic iss_run();
    logic [31:0] w, a, b, c, simm, ea, res;
    logic [3:0]  op, rd;
    logic [7:0]  nxt;
    logic        wr;
    for (int i = 0; i < 16; i++) m_reg[i] = 0;
    m_pc = 0; m_halt = 0; m_err = 0;
    for (int s = 0; s < 1000 && !m_halt; s++) begin
      w    = (m_pc < prog.size()) ? prog[m_pc] : HALTW;
      op   = w[31:28]; rd = w[27:24];
      a    = m_reg[w[23:20]]; b = m_reg[w[19:16]]; c = m_reg[rd];
      simm = {{16{w[15]}}, w[15:0]};
      ea   = a + simm;
      nxt  = m_pc + 8'd1;
      wr   = 0; res = 0;
      case (int'(op))
        0: ;
        ADD:  begin wr = 1; res = a + b; end
        SUB:  begin wr = 1; res = a - b; end
        AND_: begin wr = 1; res = a & b; end
        OR_:  begin wr = 1; res = a | b; end
        XOR_: begin wr = 1; res = a ^ b; end
        ADDI: begin wr = 1; res = a + simm; end
        LUI:  begin wr = 1; res = {w[15:0], 16'h0}; end
        LD, ST: begin
          if (ea > 255) begin m_err[1] = 1; m_halt = 1; nxt = m_pc; end
          else if (op == 4'(LD)) begin wr = 1; res = m_dmem[ea[7:0]]; end
          else m_dmem[ea[7:0]] = c;
        end
        BEQ: if (c == a) nxt = m_pc + 8'd1 + simm[7:0];
        BNE: if (c != a) nxt = m_pc + 8'd1 + simm[7:0];
        JMP: nxt = w[7:0];
`ifdef SCC_MUL_EN
        MUL: begin wr = 1; res = a * b; end
`endif
        15: begin m_halt = 1; nxt = m_pc; end
        default: begin m_err[0] = 1; m_halt = 1; nxt = m_pc; end
      endcase
      if (wr && rd != 0) m_reg[rd] = res;
      m_pc = nxt;
    end
  endtask

  typedef struct {
    string       nm;
    int          op;
    logic [31:0] a, b, exp;
    logic [1:0]  err;
  } alu_vec_t;

  alu_vec_t tbl[$];

  initial begin
    tbl = '{
      '{"add",    ADD,  32'd5,         32'hFFFF_FFFD, 32'd2,         2'b00},
      '{"sub",    SUB,  32'd5,         32'hFFFF_FFFD, 32'd8,         2'b00},
      '{"and",    AND_, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 2'b00},
      '{"or",     OR_,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 2'b00},
      '{"xor",    XOR_, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 2'b00},
      '{"add_wr", ADD,  32'hFFFF_FFFF, 32'd1,         32'd0,         2'b00},
      '{"sub_wr", SUB,  32'd0,         32'd1,         32'hFFFF_FFFF, 2'b00},
`ifdef SCC_MUL_EN
      '{"mul",    MUL,  32'd6,         32'd7,         32'd42,        2'b00},
`else
      '{"mul",    MUL,  32'd6,         32'd7,         32'd0,         2'b01},
`endif
      '{"ill_e",  ILL,  32'd1,         32'd2,         32'd0,         2'b01}
    };

    // table-driven ALU vectors: R1=a, R2=b, R3 = R1 op R2
    foreach (tbl[k]) begin
      prog = {};
      li(1, tbl[k].a); li(2, tbl[k].b);
      emit(tbl[k].op, 3, 1, 2, 0);
      load_prog(); do_reset(); run(12, 1'b1);
      chk({tbl[k].nm, "_r3"}, rf(3), tbl[k].exp);
      chk({tbl[k].nm, "_err"}, 32'(err_bits), 32'(tbl[k].err));
      chk({tbl[k].nm, "_halt"}, 32'(halt_f), 32'd1);
    end

    // ALU sequence, then reset with clk_en low must clear everything
    prog = {};
    emit(ADDI, 1, 0, 0, 5); emit(ADDI, 2, 0, 0, -3); emit(ADD, 3, 1, 2, 0);
    emit(SUB, 4, 1, 2, 0); emit(LUI, 5, 0, 0, 16'h1234);
    load_prog(); do_reset(); run(10, 1'b1);
    chk("seq_r3", rf(3), 32'd2);
    chk("seq_r4", rf(4), 32'd8);
    chk("seq_r5", rf(5), 32'h1234_0000);
    clk_en = 1'b0; do_reset();
    chk("rst_pc", pc(), 0);
    chk("rst_halt", 32'(halt_f), 0);
    chk("rst_err", 32'(err_bits), 0);
    for (int i = 0; i < 16; i++) chk($sformatf("rst_r%0d", i), rf(i), 0);

    // store/load round trip, store data visible only during the ST
    prog = {};
    emit(ADDI, 1, 0, 0, 16'h55); emit(ST, 1, 0, 0, 4); emit(LD, 6, 0, 0, 4);
    load_prog(); do_reset();
    chk("mem_dmiv_addi", dmiv, 0);
    run(1, 1'b1);
    chk("mem_dmiv_st", dmiv, 32'h55);
    run(1, 1'b1);
    chk("mem_dmiv_ld", dmiv, 0);
    run(5, 1'b1);
    chk("mem_r6", rf(6), 32'h55);

    // counted loop, PC frozen on HALT for the rest of the run
    prog = {};
    emit(ADDI, 1, 0, 0, 3); emit(ADDI, 1, 1, 0, -1); emit(BNE, 1, 0, 0, -2);
    load_prog(); do_reset(); run(50, 1'b1);
    chk("loop_pc_mid", pc(), 3);
    run(50, 1'b1);
    chk("loop_r1", rf(1), 0);
    chk("loop_halt", 32'(halt_f), 1);
    chk("loop_pc_end", pc(), 3);
    chk("loop_imv", imv, HALTW);
    chk("loop_err", 32'(err_bits), 0);
    rst = 1'b1; run(1, 1'b0); rst = 1'b0;
    chk("midrst_pc", pc(), 0);
    chk("midrst_halt", 32'(halt_f), 0);

    // JMP forward then BEQ taken backwards
    prog = {};
    emit(JMP, 0, 0, 0, 4); emit(ADDI, 1, 1, 0, 1); prog.push_back(HALTW);
    prog.push_back(HALTW); emit(BEQ, 0, 0, 0, -4);
    load_prog(); do_reset(); run(10, 1'b1);
    chk("br_r1", rf(1), 1);
    chk("br_pc", pc(), 2);

    // illegal opcode has no side effects; error stays sticky
    prog = {};
    emit(ADDI, 1, 0, 0, 1); emit(ILL, 1, 1, 1, 5); emit(ADDI, 1, 0, 0, 9);
    load_prog(); do_reset(); run(20, 1'b1);
    chk("ill_err", 32'(err_bits), 32'b01);
    chk("ill_halt", 32'(halt_f), 1);
    chk("ill_r1", rf(1), 1);

    // out-of-range load leaves rd alone
    prog = {};
    emit(ADDI, 7, 0, 0, 9); emit(LD, 7, 0, 0, 300); emit(ADDI, 8, 0, 0, 1);
    load_prog(); do_reset(); run(20, 1'b1);
    chk("ldoor_err", 32'(err_bits), 32'b10);
    chk("ldoor_halt", 32'(halt_f), 1);
    chk("ldoor_r7", rf(7), 9);
    chk("ldoor_r8", rf(8), 0);

    // clock enable hold, then R0 write discard
    prog = {};
    for (int i = 0; i < 10; i++) emit(ADDI, 1, 1, 0, 1);
    load_prog(); do_reset(); run(2, 1'b1);
    run(5, 1'b0);
    chk("hold_pc", pc(), 2);
    chk("hold_r1", rf(1), 2);
    chk("hold_imv", imv, prog[2]);
    prog = {};
    emit(ADDI, 0, 0, 0, 7); emit(ADDI, 2, 0, 0, 1);
    load_prog(); do_reset(); run(5, 1'b1);
    chk("r0_zero", rf(0), 0);
    chk("r0_read", rf(2), 1);

    // zero DMEM words 0..15 once; later trials only touch those addresses
    prog = {};
    for (int i = 0; i < 16; i++) emit(ST, 0, 0, 0, i);
    load_prog(); do_reset(); run(20, 1'b1);
    for (int i = 0; i < 256; i++) m_dmem[i] = 0;

    // random straight-line programs with random clock enable
    for (int t = 0; t < 25; t++) begin
      int op, imm, cyc;
      prog = {};
      for (int i = 0; i < 30; i++) begin
        op = $urandom_range(0, 9);
        if ($urandom_range(0, 39) == 0) op = MUL;
        if (op == LD || op == ST) begin
          imm = ($urandom_range(0, 19) == 0) ? $urandom_range(256, 300) : $urandom_range(0, 15);
          emit(op, $urandom_range(0, 15), 0, 0, imm);
        end else begin
          emit(op, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
               $urandom_range(0, 65535));
        end
      end
      load_prog(); do_reset();
      cyc = 0;
      while (!halt_f && cyc < 2000) begin
        clk_en = 1'($urandom_range(0, 1)); tick(); cyc++;
      end
      chk($sformatf("rnd%0d_halted", t), 32'(halt_f), 1);
      iss_run();
      chk($sformatf("rnd%0d_err", t), 32'(err_bits), 32'(m_err));
      chk($sformatf("rnd%0d_pc", t), pc(), 32'(m_pc));
      for (int i = 0; i < 16; i++) chk($sformatf("rnd%0d_r%0d", t, i), rf(i), m_reg[i]);
      for (int i = 0; i < 16; i++) chk($sformatf("rnd%0d_m%0d", t, i), dut.dmem_q[i], m_dmem[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
